// File: rtl/mem_responder.sv
// Memory-side responder: request/MFC handshake with a programmable wait latency.
// Optional MEMRESP_RANGE_CHK_EN adds an err output and suppresses out-of-range accesses.
module mem_responder #(
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memEN,
  input  logic          RW,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          MFC,
  output logic          busy
`ifdef MEMRESP_RANGE_CHK_EN
  ,
  output logic          err
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic          rw_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] mem [DEPTH];

  logic accept, complete, write_en;
  logic [IW-1:0] idx;

  assign accept   = (state_q == S_IDLE) && memEN;
  assign complete = (state_q == S_BUSY) && memEN && (cnt_q == '0);
  assign idx      = addr_q[IW-1:0];

`ifdef MEMRESP_RANGE_CHK_EN
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  logic oor_q;
  assign write_en = complete && !rw_q && !oor_q;
`else
  assign write_en = complete && !rw_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a dropped memEN in BUSY aborts the access
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (memEN) state_d = S_BUSY;
      S_BUSY: begin
        if (!memEN)              state_d = S_IDLE;
        else if (cnt_q == '0)    state_d = S_DONE;
      end
      S_DONE: if (!memEN) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Outputs decode directly from the state register, so they are glitch-free
  always_comb begin
    MFC  = (state_q == S_DONE);
    busy = (state_q != S_IDLE);
`ifdef MEMRESP_RANGE_CHK_EN
    err  = (state_q == S_DONE) && oor_q;
`endif
  end

  // Request capture, wait counter and read-data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      cnt_q    <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      data_out <= '0;
`ifdef MEMRESP_RANGE_CHK_EN
      oor_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt_q   <= CW'(LAT - 1);
        addr_q  <= addr;
        rw_q    <= RW;
        wdata_q <= data_in;
`ifdef MEMRESP_RANGE_CHK_EN
        oor_q   <= 32'(addr) >= DEPTH_W;
`endif
      end else if ((state_q == S_BUSY) && memEN && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (complete && rw_q) begin
`ifdef MEMRESP_RANGE_CHK_EN
        data_out <= oor_q ? '0 : mem[idx];
`else
        data_out <= mem[idx];
`endif
      end
    end
  end

  // NOTE: the array has no reset; contents survive rst, and state is IDLE while rst is high so no write can commit.
  always_ff @(posedge clk) begin
    if (write_en) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: per-cycle behavioural model plus directed literal checks.
module tb_mem_responder;

  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int LAT = 2;
`ifdef MEMRESP_RANGE_CHK_EN
  localparam int DEPTH = 128;
`else
  localparam int DEPTH = 256;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          memEN = 1'b0;
  logic          RW = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          MFC, busy;
`ifdef MEMRESP_RANGE_CHK_EN
  logic          err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mem_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .memEN    (memEN),
    .RW       (RW),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .MFC      (MFC),
    .busy     (busy)
`ifdef MEMRESP_RANGE_CHK_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a request is "active" from acceptance until memEN drops;
  // it completes LAT edges after acceptance, and the access happens at that edge.
  bit            m_active = 1'b0;
  int            m_age    = 0;
  logic [AW-1:0] m_addr;
  logic          m_rw;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_dout   = '0;
  logic [DW-1:0] m_mem [DEPTH];

  function automatic bit m_oor(input logic [AW-1:0] a);
`ifdef MEMRESP_RANGE_CHK_EN
    return int'(a) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_age    = 0;
      m_dout   = '0;
    end else if (!m_active) begin
      if (memEN) begin
        m_active = 1'b1;
        m_age    = 0;
        m_addr   = addr;
        m_rw     = RW;
        m_data   = data_in;
      end
    end else if (!memEN) begin
      m_active = 1'b0;
    end else if (m_age < LAT) begin
      m_age++;
      if (m_age == LAT) begin
        if (m_rw) m_dout = m_oor(m_addr) ? '0 : m_mem[int'(m_addr) % DEPTH];
        else if (!m_oor(m_addr)) m_mem[int'(m_addr) % DEPTH] = m_data;
      end
    end
  end

  // Compare process, sampled on the falling edge
  always @(negedge clk) begin
    logic exp_mfc;
    exp_mfc = m_active && (m_age == LAT);
    check("mfc",      32'(MFC),      32'(exp_mfc));
    check("busy",     32'(busy),     32'(m_active));
    check("data_out", 32'(data_out), 32'(m_dout));
`ifdef MEMRESP_RANGE_CHK_EN
    check("err",      32'(err),      32'(exp_mfc && m_oor(m_addr)));
`endif
  end

  // One full handshake, called just after a rising edge. Scrambles the request
  // inputs after acceptance, holds memEN `hold` edges past MFC, then releases.
  task automatic do_req(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int hold, output logic [DW-1:0] dout, output int edges,
                        output int mfc_cycles, output logic e);
    memEN = 1'b1; RW = rw; addr = a; data_in = d;
    edges = 0; mfc_cycles = 0; dout = '0; e = 1'b0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin RW = ~rw; addr = ~a; data_in = ~d; end
    end while (!MFC && edges < 40);
    if (!MFC) check("mfc_timeout", 32'(MFC), 32'd1);
    dout = data_out;
`ifdef MEMRESP_RANGE_CHK_EN
    e = err;
`endif
    mfc_cycles = 1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (MFC) mfc_cycles++;
    end
    memEN = 1'b0;
    @(posedge clk); #1;
    check("mfc_release",  32'(MFC),  32'd0);
    check("busy_release", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] dout;
    int edges, cyc;
    logic e;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_mfc",  32'(MFC),      32'd0);
    check("rst_busy", 32'(busy),     32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: write, MFC on the LAT-th edge after acceptance
    do_req(1'b0, 8'h05, 16'h1234, 0, dout, edges, cyc, e);
    check("t1_edges", 32'(edges), 32'(LAT + 1));

    // 2: read back, then a write leaves data_out alone
    do_req(1'b1, 8'h05, 16'h0000, 0, dout, edges, cyc, e);
    check("t2_read", 32'(dout), 32'h1234);
    check("t2_edges", 32'(edges), 32'(LAT + 1));
    do_req(1'b0, 8'h06, 16'hBEEF, 0, dout, edges, cyc, e);
    check("t2_dout_kept", 32'(data_out), 32'h1234);

    // 3: memEN held 10 extra cycles after MFC
    do_req(1'b1, 8'h06, 16'h0000, 10, dout, edges, cyc, e);
    check("t3_read", 32'(dout), 32'hBEEF);
    check("t3_mfc_cycles", 32'(cyc), 32'd11);

    // 4: abort one cycle into BUSY
    do_req(1'b0, 8'h10, 16'h1111, 0, dout, edges, cyc, e);
    do_req(1'b0, 8'h20, 16'h2222, 0, dout, edges, cyc, e);
    memEN = 1'b1; RW = 1'b0; addr = 8'h10; data_in = 16'hAAAA;
    @(posedge clk); #1;
    check("t4_busy", 32'(busy), 32'd1);
    memEN = 1'b0;
    @(posedge clk); #1;
    check("t4_abort_busy", 32'(busy), 32'd0);
    check("t4_abort_mfc",  32'(MFC),  32'd0);
    repeat (3) @(posedge clk);
    #1;
    do_req(1'b1, 8'h10, 16'h0000, 0, dout, edges, cyc, e);
    check("t4_read", 32'(dout), 32'h1111);

    // 5: asynchronous reset in the middle of BUSY
    memEN = 1'b1; RW = 1'b0; addr = 8'h20; data_in = 16'h5555;
    @(posedge clk); #1;
    check("t5_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_mfc",  32'(MFC),      32'd0);
    check("t5_busy0", 32'(busy),    32'd0);
    check("t5_dout", 32'(data_out), 32'd0);
    memEN = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    do_req(1'b1, 8'h20, 16'h0000, 0, dout, edges, cyc, e);
    check("t5_read", 32'(dout), 32'h2222);

`ifdef MEMRESP_RANGE_CHK_EN
    // 6: out-of-range accesses with DEPTH=128
    do_req(1'b0, 8'h90, 16'h7777, 2, dout, edges, cyc, e);
    check("t6_wr_err", 32'(e), 32'd1);
    check("t6_wr_edges", 32'(edges), 32'(LAT + 1));
    do_req(1'b1, 8'h90, 16'h0000, 0, dout, edges, cyc, e);
    check("t6_rd_err", 32'(e), 32'd1);
    check("t6_rd_data", 32'(dout), 32'd0);
    check("t6_err_clear", 32'(err), 32'd0);
    do_req(1'b1, 8'h10, 16'h0000, 0, dout, edges, cyc, e);
    check("t6_alias_err", 32'(e), 32'd0);
    check("t6_alias_data", 32'(dout), 32'h1111);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the fetch/execute memory handshake. It accepts requests on memEN/RW/addr/data_in from the instruction-fetch and execute FSMs. It performs the read or write on an internal word array after a programmable number of wait cycles. It signals completion with MFC, which it holds until the initiator drops memEN.

Parameters:
DW, 16, data word width in bits
AW, 8, address width in bits
DEPTH, 256, number of words in the array; power of two, at most 2^AW
LAT, 2, wait cycles from request acceptance to MFC; legal range 1..15

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
memEN  input  1  request strobe; held high by the initiator until MFC is seen
RW  input  1  1 = read (memory to data_out), 0 = write (data_in to memory)
addr  input  AW  word address (MAR value)
data_in  input  DW  write data (MDR value)
data_out  output  DW  read data, registered
MFC  output  1  memory function complete, registered
busy  output  1  high in states BUSY and DONE

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, MFC=0, busy=0, data_out=0, wait counter=0. Array contents are not cleared. A write that has not yet completed when reset arrives is never committed.
- States: IDLE, BUSY, DONE. MFC=1 only in DONE. busy=1 in BUSY and DONE.
- IDLE: on a rising edge with memEN=1:
  - latch addr, RW, data_in
  - load counter with LAT-1
  - go to BUSY
  - if memEN=0, stay in IDLE.
- BUSY, memEN=0: abort. Go to IDLE, no array access, MFC stays 0.
- BUSY, memEN=1, counter≠0: decrement the counter.
- BUSY, memEN=1, counter=0: perform the access and go to DONE.
  - Read: data_out <= array[latched addr].
  - Write: array[latched addr] <= latched data_in; data_out unchanged.
- Timing: MFC rises on the LAT-th rising edge after the accepting edge. Read data is valid in the same cycle MFC is first high.
- DONE, memEN=1: hold MFC=1 and hold data_out.
- DONE, memEN=0: go to IDLE, MFC=0. A new request needs memEN low for at least one sampled edge, so a memEN held high is never serviced twice.
- addr, RW and data_in changes after the accepting edge are ignored until the next acceptance.
- data_out changes only on read completion or reset. It holds its last read value across writes and idle periods.
- Addresses index the array modulo DEPTH (low log2(DEPTH) bits). The Optional Feature below changes this.
- Back-to-back: a drop of memEN in DONE followed by a rise on the next edge gives IDLE for one cycle, then acceptance.

Optional Feature:
Macro MEMRESP_RANGE_CHK_EN.
- Defined:
  - An extra output port err (1 bit) is present; it resets to 0.
  - An access whose latched addr ≥ DEPTH still completes with normal MFC timing.
  - Out-of-range write: the array is not modified.
  - Out-of-range read: data_out is loaded with 0.
  - err=1 exactly while MFC=1 for that access, and 0 otherwise.
- Undefined: no err port, and addresses wrap modulo DEPTH as above.

Test Plan:
1. Reset, then LAT=2; write addr=0x05, data_in=0x1234 (memEN held) -> MFC rises 2 edges after acceptance, stays high until memEN drops, then falls on the next edge; busy tracks BUSY/DONE.
2. Read addr=0x05 after test 1 -> data_out=0x1234 in the first MFC-high cycle. Then write addr=0x06, data_in=0xBEEF -> data_out still 0x1234.
3. Hold memEN high for 10 cycles after MFC on a read -> exactly one access, MFC high throughout; lowering memEN gives MFC=0 next edge and busy=0.
4. Drop memEN one cycle into BUSY during a write of 0xAAAA to addr 0x10 -> MFC never asserts, returns to IDLE; later read of 0x10 returns prior contents.
5. Assert rst asynchronously mid-BUSY during a write of 0x5555 to 0x20 -> MFC, busy and data_out go 0 immediately without waiting for a clock edge; 0x20 unchanged.
6. With MEMRESP_RANGE_CHK_EN and DEPTH=128: write 0x7777 to 0x90, then read 0x90 -> both complete with err=1 during MFC; read data_out=0; read of 0x10 (alias) unchanged.
